image_ram_arbiter: RTL and testbench

Arbiter and sequencer for the dual-port image line RAM (port A read, port B write), placed between the RAM and its three clients: the display line filler, the CA generator and the CA reset generator. It replaces the combinational address/enable muxing in the top level with explicit request/grant handshakes. It also provides tagged read-data return, write-to-read bypass on address collision, round-robin write arbitration and a starvation monitor. The display read path always has absolute priority so pixel output never stalls.

---
 rtl/image_ram_arbiter_if.sv | 60 ++++++
 rtl/image_ram_arbiter.sv | 137 +++++++++++++
 tb/tb_image_ram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_ram_arbiter_if.sv
// Request/grant bundle between the image line RAM arbiter,
// its three clients and the dual-port line RAM.
interface image_ram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;

  logic          gen_rreq;
  logic [AW-1:0] gen_raddr;
  logic          gen_rgnt;
  logic          gen_rvalid;
  logic [DW-1:0] gen_rdata;

  logic          gen_wreq;
  logic [AW-1:0] gen_waddr;
  logic [DW-1:0] gen_wdata;
  logic          gen_wgnt;

  logic          rst_wreq;
  logic [AW-1:0] rst_waddr;
  logic [DW-1:0] rst_wdata;
  logic          rst_wgnt;

  logic          ram_ena;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_douta;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dinb;

  modport slave (
    input  disp_req, disp_addr,
    input  gen_rreq, gen_raddr,
    input  gen_wreq, gen_waddr, gen_wdata,
    input  rst_wreq, rst_waddr, rst_wdata,
    input  ram_douta,
    output disp_rvalid, disp_rdata,
    output gen_rgnt, gen_rvalid, gen_rdata,
    output gen_wgnt, rst_wgnt,
    output ram_ena, ram_addra,
    output ram_enb, ram_addrb, ram_dinb
  );

  modport master (
    output disp_req, disp_addr,
    output gen_rreq, gen_raddr,
    output gen_wreq, gen_waddr, gen_wdata,
    output rst_wreq, rst_waddr, rst_wdata,
    output ram_douta,
    input  disp_rvalid, disp_rdata,
    input  gen_rgnt, gen_rvalid, gen_rdata,
    input  gen_wgnt, rst_wgnt,
    input  ram_ena, ram_addra,
    input  ram_enb, ram_addrb, ram_dinb
  );
endinterface

// File: rtl/image_ram_arbiter.sv
// Image line RAM arbiter: display-priority port A, round-robin
// port B, tagged read return with write bypass, starvation flag.
module image_ram_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  image_ram_arbiter_if.slave bus,
  output logic starve_flag
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic          vld;
    logic          gen;
    logic          byp;
    logic [DW-1:0] bdat;
  } tag_t;

  tag_t          pipe [RD_LAT];
  tag_t          tag_in;
  tag_t          tag_out;
  logic          last_rst;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          disp_rd;
  logic          gen_rd;
  logic          gen_w;
  logic          rst_w;
  logic          tie;
  logic          hit;
  logic          ena;
  logic          enb;
  logic [AW-1:0] addra;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic [DW-1:0] rdata;

  always_comb begin
    disp_rd = rst_n & bus.disp_req;
    gen_rd  = rst_n & bus.gen_rreq & ~bus.disp_req;
    tie     = bus.gen_wreq & bus.rst_wreq;
    // last_rst set means the reset writer took the previous tie
    gen_w   = rst_n & bus.gen_wreq
            & (~bus.rst_wreq | last_rst);
    rst_w   = rst_n & bus.rst_wreq
            & (~bus.gen_wreq | ~last_rst);
    ena     = disp_rd | gen_rd;
    enb     = gen_w | rst_w;
  end

  always_comb begin
    addra = '0;
    unique case (1'b1)
      disp_rd: addra = bus.disp_addr;
      gen_rd:  addra = bus.gen_raddr;
      default: ;
    endcase
  end

  always_comb begin
    addrb = '0;
    dinb  = '0;
    unique case (1'b1)
      gen_w: begin
        addrb = bus.gen_waddr;
        dinb  = bus.gen_wdata;
      end
      rst_w: begin
        addrb = bus.rst_waddr;
        dinb  = bus.rst_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit         = ena & enb & (addra == addrb);
    tag_in.vld  = ena;
    tag_in.gen  = gen_rd;
    tag_in.byp  = hit;
    tag_in.bdat = hit ? dinb : '0;
  end

  always_comb begin
    cnt_nxt = '0;
    if (bus.gen_rreq & ~gen_rd) begin
      if (starve_cnt == CW'(STARVE_MAX))
        cnt_nxt = starve_cnt;
      else
        cnt_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++)
        pipe[i] <= '0;
      last_rst    <= 1'b1;
      starve_cnt  <= '0;
      starve_flag <= 1'b0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++)
        pipe[i] <= pipe[i-1];
      if (tie)
        last_rst <= rst_w;
      starve_cnt <= cnt_nxt;
      if (cnt_nxt == CW'(STARVE_MAX))
        starve_flag <= 1'b1;
    end
  end

  always_comb begin
    tag_out = pipe[RD_LAT-1];
    rdata   = '0;
    if (tag_out.vld)
      rdata = tag_out.byp ? tag_out.bdat
                          : bus.ram_douta;
  end

  assign bus.gen_rgnt    = gen_rd;
  assign bus.gen_wgnt    = gen_w;
  assign bus.rst_wgnt    = rst_w;
  assign bus.ram_ena     = ena;
  assign bus.ram_addra   = addra;
  assign bus.ram_enb     = enb;
  assign bus.ram_addrb   = addrb;
  assign bus.ram_dinb    = dinb;
  assign bus.disp_rvalid = tag_out.vld & ~tag_out.gen;
  assign bus.gen_rvalid  = tag_out.vld & tag_out.gen;
  assign bus.disp_rdata  = rdata;
  assign bus.gen_rdata   = rdata;
endmodule

// File: tb/tb_image_ram_arbiter.sv
// Directed table plus hand sequences and a randomized
// scoreboard run for image_ram_arbiter with RD_LAT=2.
module tb_image_ram_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int SMX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic starve_flag;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  image_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  image_ram_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(LAT), .STARVE_MAX(SMX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .starve_flag(starve_flag)
  );

  function automatic logic [15:0] init_val(
    input logic [9:0] a);
    if (a == 10'h010) return 16'h1234;
    return {6'b000100, a};
  endfunction

  // line RAM model: read-first, fixed two-cycle read latency
  logic [15:0] mem [1024];
  bit          wr_seen [1024];
  logic [15:0] rp0 = '0;
  logic [15:0] rp1 = '0;
  always @(posedge clk) begin
    if (bus.ram_enb) begin
      mem[bus.ram_addrb]     <= bus.ram_dinb;
      wr_seen[bus.ram_addrb] <= 1'b1;
    end
    rp0 <= wr_seen[bus.ram_addra] ? mem[bus.ram_addra]
                                  : init_val(bus.ram_addra);
    rp1 <= rp0;
  end
  assign bus.ram_douta = rp1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(
    input logic dr, input logic [9:0] da,
    input logic gr, input logic [9:0] ga,
    input logic gw, input logic [9:0] gwa,
    input logic [15:0] gwd,
    input logic rw, input logic [9:0] rwa,
    input logic [15:0] rwd);
    bus.disp_req  = dr;
    bus.disp_addr = da;
    bus.gen_rreq  = gr;
    bus.gen_raddr = ga;
    bus.gen_wreq  = gw;
    bus.gen_waddr = gwa;
    bus.gen_wdata = gwd;
    bus.rst_wreq  = rw;
    bus.rst_waddr = rwa;
    bus.rst_wdata = rwd;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [127:0] all_out();
    return {bus.gen_rgnt, bus.gen_wgnt, bus.rst_wgnt,
            bus.ram_ena, bus.ram_enb, bus.disp_rvalid,
            bus.gen_rvalid, starve_flag, bus.ram_addra,
            bus.ram_addrb, bus.ram_dinb, bus.disp_rdata,
            bus.gen_rdata};
  endfunction

  typedef struct {
    logic dr; logic [9:0] da;
    logic gr; logic [9:0] ga;
    logic gw; logic [9:0] gwa; logic [15:0] gwd;
    logic rw; logic [9:0] rwa; logic [15:0] rwd;
    logic e_rg; logic e_ena; logic [9:0] e_aa;
    logic e_gwg; logic e_rwg;
    logic [9:0] e_ab; logic [15:0] e_db;
    logic e_dv; logic e_gv; logic [15:0] e_rd;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        gen;
    logic [15:0] d;
  } rq_t;

  vec_t        vt [11];
  rq_t         q [$];
  logic [15:0] shadow [16];

  task automatic ret_check();
    logic due, egv, edv, act_v;
    logic [15:0] ed, ad;
    due = (q.size() > 0) && (q[0].cyc + LAT == cyc);
    egv = due && q[0].gen;
    edv = due && !q[0].gen;
    ed  = due ? q[0].d : 16'h0;
    act_v = bus.disp_rvalid | bus.gen_rvalid;
    ad  = bus.disp_rvalid ? bus.disp_rdata
                          : bus.gen_rdata;
    if (!act_v) ad = 16'h0;
    chk("rnd_ret",
        {bus.disp_rvalid, bus.gen_rvalid, ad},
        {edv, egv, ed});
    if (due) void'(q.pop_front());
  endtask

  initial begin
    logic pgr, pgw, prw, dr, mlast;
    logic gotr, gotgw, gotrw;
    logic mgr, mgw, mrw;
    logic [9:0] da, ga, gwa, rwa, ra, wa;
    logic [15:0] gwd, rwd, wd, ed;

    vt[0]  = '{0,0,0,0,0,0,0,0,0,0,
               0,0,0,0,0,0,0,0,0,0};
    vt[1]  = '{1,'h005,1,'h006,0,0,0,0,0,0,
               0,1,'h005,0,0,0,0,0,0,0};
    vt[2]  = '{0,0,1,'h006,0,0,0,0,0,0,
               1,1,'h006,0,0,0,0,0,0,0};
    vt[3]  = '{0,0,0,0,1,'h020,'hAAAA,1,'h030,'h5555,
               0,0,0,1,0,'h020,'hAAAA,1,0,'h1005};
    vt[4]  = '{0,0,0,0,1,'h020,'hAAAA,1,'h030,'h5555,
               0,0,0,0,1,'h030,'h5555,0,1,'h1006};
    vt[5]  = '{0,0,0,0,1,'h020,'hAAAA,1,'h030,'h5555,
               0,0,0,1,0,'h020,'hAAAA,0,0,0};
    vt[6]  = '{0,0,0,0,1,'h020,'hAAAA,1,'h030,'h5555,
               0,0,0,0,1,'h030,'h5555,0,0,0};
    vt[7]  = '{0,0,0,0,0,0,0,1,'h031,'h0031,
               0,0,0,0,1,'h031,'h0031,0,0,0};
    vt[8]  = '{0,0,0,0,1,'h021,'h2121,1,'h032,'h3232,
               0,0,0,1,0,'h021,'h2121,0,0,0};
    vt[9]  = '{0,0,0,0,1,'h022,'h2222,0,0,0,
               0,0,0,1,0,'h022,'h2222,0,0,0};
    vt[10] = '{0,0,0,0,1,'h023,'h2323,1,'h033,'h3333,
               0,0,0,0,1,'h033,'h3333,0,0,0};

    // reset: requests present but nothing may be granted
    set_in(1, 5, 1, 6, 1, 7, 16'h1111, 1, 8, 16'h2222);
    #22;
    chk("reset_outputs", all_out(), 128'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("idle_outputs", all_out(), 128'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_in(vt[i].dr, vt[i].da, vt[i].gr, vt[i].ga,
             vt[i].gw, vt[i].gwa, vt[i].gwd,
             vt[i].rw, vt[i].rwa, vt[i].rwd);
      #2;
      chk($sformatf("portA_%0d", i),
          {bus.gen_rgnt, bus.ram_ena, bus.ram_addra},
          {vt[i].e_rg, vt[i].e_ena, vt[i].e_aa});
      chk($sformatf("portB_%0d", i),
          {bus.gen_wgnt, bus.rst_wgnt, bus.ram_enb,
           bus.ram_addrb, bus.ram_dinb},
          {vt[i].e_gwg, vt[i].e_rwg,
           vt[i].e_gwg | vt[i].e_rwg,
           vt[i].e_ab, vt[i].e_db});
      chk($sformatf("rvalid_%0d", i),
          {bus.disp_rvalid, bus.gen_rvalid},
          {vt[i].e_dv, vt[i].e_gv});
      if (vt[i].e_dv)
        chk($sformatf("disp_rdata_%0d", i),
            bus.disp_rdata, vt[i].e_rd);
      if (vt[i].e_gv)
        chk($sformatf("gen_rdata_%0d", i),
            bus.gen_rdata, vt[i].e_rd);
    end

    // write/read collision returns the new word
    @(negedge clk);
    set_in(0, 0, 1, 'h010, 1, 'h010, 'hBEEF, 0, 0, 0);
    #2 chk("byp_gnt", {bus.gen_rgnt, bus.gen_wgnt}, 2'b11);
    @(negedge clk);
    set_in(0, 0, 1, 'h011, 1, 'h012, 'h7777, 0, 0, 0);
    #2 chk("nobyp_gnt", {bus.gen_rgnt, bus.gen_wgnt}, 2'b11);
    @(negedge clk);
    idle();
    #2 chk("byp_ret", {bus.gen_rvalid, bus.gen_rdata},
           {1'b1, 16'hBEEF});
    @(negedge clk);
    #2 chk("nobyp_ret", {bus.gen_rvalid, bus.gen_rdata},
           {1'b1, 16'h1011});
    @(negedge clk);
    set_in(0, 0, 1, 'h010, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    @(negedge clk);
    #2 chk("ram_after_wr", {bus.gen_rvalid, bus.gen_rdata},
           {1'b1, 16'hBEEF});

    // display blocks generator reads for STARVE_MAX cycles
    for (int i = 0; i < SMX; i++) begin
      @(negedge clk);
      set_in(1, 10'(10'h040 + i), 1, 'h050, 0, 0, 0, 0, 0, 0);
      #2 chk($sformatf("starve_pre_%0d", i),
             {bus.gen_rgnt, starve_flag}, 2'b00);
    end
    @(negedge clk);
    set_in(0, 0, 1, 'h050, 0, 0, 0, 0, 0, 0);
    #2 chk("starve_set", {bus.gen_rgnt, starve_flag}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      #2 chk("starve_sticky", starve_flag, 1'b1);
    end

    // reset pulse while a read is in flight
    @(negedge clk);
    set_in(1, 'h007, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(1, 5, 1, 6, 1, 7, 16'h1111, 1, 8, 16'h2222);
    rst_n = 1'b0;
    #1 chk("midrst_outputs", all_out(), 128'h0);
    #2;
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2 chk("no_stale_rvalid",
             {bus.disp_rvalid, bus.gen_rvalid, starve_flag},
             3'b000);
    end

    // randomized traffic against a shadow memory
    for (int i = 0; i < 16; i++)
      shadow[i] = init_val(10'(10'h100 + i));
    pgr = 0; pgw = 0; prw = 0;
    gotr = 0; gotgw = 0; gotrw = 0;
    mlast = 1'b1;
    ga = 0; gwa = 0; rwa = 0; gwd = 0; rwd = 0;
    cyc = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      dr = ($urandom_range(0, 2) == 0);
      da = 10'h100 + 10'($urandom_range(0, 15));
      if (!pgr || gotr) begin
        pgr = 1'($urandom_range(0, 1));
        ga  = 10'h100 + 10'($urandom_range(0, 15));
      end
      if (!pgw || gotgw) begin
        pgw = 1'($urandom_range(0, 1));
        gwa = 10'h100 + 10'($urandom_range(0, 15));
        gwd = 16'($urandom);
      end
      if (!prw || gotrw) begin
        prw = 1'($urandom_range(0, 1));
        rwa = 10'h100 + 10'($urandom_range(0, 15));
        rwd = 16'($urandom);
      end
      set_in(dr, da, pgr, ga, pgw, gwa, gwd, prw, rwa, rwd);
      #2;
      mgr = pgr & ~dr;
      mgw = pgw & (~prw | mlast);
      mrw = prw & (~pgw | ~mlast);
      chk("rnd_gnt",
          {bus.gen_rgnt, bus.gen_wgnt, bus.rst_wgnt},
          {mgr, mgw, mrw});
      ret_check();
      wa = mgw ? gwa : rwa;
      wd = mgw ? gwd : rwd;
      if (dr | mgr) begin
        ra = dr ? da : ga;
        ed = ((mgw | mrw) && wa == ra) ? wd
                                       : shadow[ra[3:0]];
        q.push_back('{cyc, mgr, ed});
      end
      if (mgw | mrw) shadow[wa[3:0]] = wd;
      if (pgw & prw) mlast = mrw;
      gotr = mgr; gotgw = mgw; gotrw = mrw;
      cyc++;
    end
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      idle();
      #2 ret_check();
      cyc++;
    end
    chk("rnd_drained", 128'(q.size()), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
